// File: rtl/rx_loader_pkg.sv
// Shared constants for the receive-side loader/sequencer.
//   CMD_*   : 32-bit command words recognised while idle
//   ST_*    : one-byte status codes handed to the transmitter
//   state_t : sequencer state encoding
package rx_loader_pkg;

    localparam logic [31:0] CMD_LOAD = 32'h0000_0001;
    localparam logic [31:0] CMD_RUN  = 32'h0000_0002;
    localparam logic [31:0] CMD_STEP = 32'h0000_0003;
    localparam logic [31:0] CMD_HALT = 32'h0000_0004;

    localparam logic [7:0] ST_OK   = 8'h4B;
    localparam logic [7:0] ST_HALT = 8'h48;
    localparam logic [7:0] ST_ERR  = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_RUN,
        S_STEP
    } state_t;

endpackage

// File: rtl/rx_loader_ctrl_if.sv
// Bundle of the loader's data-path signals.
//   rx_valid/rx_data : assembled receive word from the UART side
//   mips_halt        : halt level from the core
//   imem_*           : instruction-memory write port
//   mips_enable/reset: core clock-enable and reset hold
//   tx_start/tx_data : status byte to the transmit side
//   error            : sticky protocol error
// master = the loader controller, slave = its environment.
interface rx_loader_ctrl_if #(parameter int ADDR_W = 8);
    logic              rx_valid;
    logic [31:0]       rx_data;
    logic              mips_halt;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              mips_enable;
    logic              mips_reset;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              error;

    modport master (
        input  rx_valid, rx_data, mips_halt,
        output imem_we, imem_addr, imem_wdata, mips_enable, mips_reset,
               tx_start, tx_data, error
    );

    modport slave (
        output rx_valid, rx_data, mips_halt,
        input  imem_we, imem_addr, imem_wdata, mips_enable, mips_reset,
               tx_start, tx_data, error
    );
endinterface

// File: rtl/rx_loader_ctrl.sv
// Command sequencer between the UART word assembler and the MIPS core.
// Decodes receive words as commands or payload, loads a program image
// into instruction memory, gates the core clock-enable for run/step and
// reports status bytes.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : rx_loader_ctrl_if master modport (all data-path signals)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a command word
// LEN    | next word is the image length N
// LOAD   | writing N payload words at sequential addresses
// RUN    | core free-running until halt
// STEP   | core enabled for this single cycle
module rx_loader_ctrl
    import rx_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    rx_loader_ctrl_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    state_t            state_q, state_n;
    logic              loaded_q, loaded_n;
    logic              error_q, error_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              imem_we_q, imem_we_n;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_n;
    logic [31:0]       imem_wdata_q, imem_wdata_n;
    logic              mips_enable_q, mips_enable_n;
    logic              mips_reset_q, mips_reset_n;
    logic              tx_start_q, tx_start_n;
    logic [7:0]        tx_data_q, tx_data_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            loaded_q      <= 1'b0;
            error_q       <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            mips_enable_q <= 1'b0;
            mips_reset_q  <= 1'b1;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_n;
            loaded_q      <= loaded_n;
            error_q       <= error_n;
            cnt_q         <= cnt_n;
            addr_q        <= addr_n;
            imem_we_q     <= imem_we_n;
            imem_addr_q   <= imem_addr_n;
            imem_wdata_q  <= imem_wdata_n;
            mips_enable_q <= mips_enable_n;
            mips_reset_q  <= mips_reset_n;
            tx_start_q    <= tx_start_n;
            tx_data_q     <= tx_data_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        loaded_n      = loaded_q;
        error_n       = error_q;
        cnt_n         = cnt_q;
        addr_n        = addr_q;
        imem_we_n     = 1'b0;
        imem_addr_n   = imem_addr_q;
        imem_wdata_n  = imem_wdata_q;
        mips_enable_n = 1'b0;
        tx_start_n    = 1'b0;
        tx_data_n     = tx_data_q;
        // Built from the current registers so it falls one cycle after
        // the final load write, not together with it.
        mips_reset_n  = ~loaded_q | (state_q == S_LEN) | (state_q == S_LOAD);

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_LOAD: begin
                            loaded_n = 1'b0;
                            error_n  = 1'b0;
                            state_n  = S_LEN;
                        end
                        CMD_RUN, CMD_STEP: begin
                            if (loaded_q) begin
                                state_n       = (bus.rx_data == CMD_RUN) ? S_RUN : S_STEP;
                                mips_enable_n = 1'b1;
                            end else begin
                                tx_start_n = 1'b1;
                                tx_data_n  = ST_ERR;
                                error_n    = 1'b1;
                            end
                        end
                        CMD_HALT: ;
                        default: begin
                            tx_start_n = 1'b1;
                            tx_data_n  = ST_ERR;
                            error_n    = 1'b1;
                        end
                    endcase
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != 32'd0 && bus.rx_data <= DEPTH) begin
                        cnt_n   = bus.rx_data[CNT_W-1:0];
                        addr_n  = '0;
                        state_n = S_LOAD;
                    end else begin
                        tx_start_n = 1'b1;
                        tx_data_n  = ST_ERR;
                        error_n    = 1'b1;
                        state_n    = S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                if (bus.rx_valid) begin
                    imem_we_n    = 1'b1;
                    imem_addr_n  = addr_q;
                    imem_wdata_n = bus.rx_data;
                    addr_n       = addr_q + 1'b1;
                    cnt_n        = cnt_q - 1'b1;
                    // Terminal count: this is the Nth word.
                    if (cnt_q == CNT_W'(1)) begin
                        loaded_n   = 1'b1;
                        tx_start_n = 1'b1;
                        tx_data_n  = ST_OK;
                        state_n    = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                mips_enable_n = 1'b1;
                if (bus.mips_halt || (bus.rx_valid && bus.rx_data == CMD_HALT)) begin
                    mips_enable_n = 1'b0;
                    tx_start_n    = 1'b1;
                    tx_data_n     = ST_HALT;
                    state_n       = S_IDLE;
                end
            end
            S_STEP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.imem_we     = imem_we_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_wdata  = imem_wdata_q;
    assign bus.mips_enable = mips_enable_q;
    assign bus.mips_reset  = mips_reset_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_rx_loader_ctrl.sv
module tb_rx_loader_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rx_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus();
    rx_loader_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 idle, 1 expecting length, 2 loading, 3 running
    bit m_loaded;
    bit m_err;
    int m_mode;
    int m_left;
    int m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rst();
        return !m_loaded || m_mode == 1 || m_mode == 2;
    endfunction

    task automatic idle_checks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_we", bus.imem_we, 0);
            chk("idle_tx", bus.tx_start, 0);
            chk("idle_en", bus.mips_enable, (m_mode == 3));
            if (i == 0) chk("mips_reset", bus.mips_reset, exp_rst());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_en", bus.mips_enable, 0);
        chk("rst_mrst", bus.mips_reset, 1);
        chk("rst_tx", bus.tx_start, 0);
        chk("rst_txd", bus.tx_data, 0);
        chk("rst_err", bus.error, 0);
        reset = 1'b0;
        m_loaded = 0; m_err = 0; m_mode = 0; m_left = 0; m_addr = 0;
        idle_checks(2);
    endtask

    task automatic send(input logic [31:0] w, input bit halt);
        bit ex_we = 0;
        bit ex_tx = 0;
        bit ex_step = 0;
        int ex_addr = 0;
        logic [7:0] ex_txd = 8'h00;
        bit pre_rst;
        pre_rst = exp_rst();
        case (m_mode)
            0: begin
                if (w == 32'd1) begin
                    m_loaded = 0; m_err = 0; m_mode = 1;
                end else if (w == 32'd2 || w == 32'd3) begin
                    if (!m_loaded) begin
                        ex_tx = 1; ex_txd = 8'h45; m_err = 1;
                    end else if (w == 32'd2) m_mode = 3;
                    else ex_step = 1;
                end else if (w != 32'd4) begin
                    ex_tx = 1; ex_txd = 8'h45; m_err = 1;
                end
            end
            1: begin
                if (w >= 32'd1 && w <= 32'(DEPTH)) begin
                    m_left = int'(w); m_addr = 0; m_mode = 2;
                end else begin
                    ex_tx = 1; ex_txd = 8'h45; m_err = 1; m_mode = 0;
                end
            end
            2: begin
                ex_we = 1; ex_addr = m_addr;
                m_addr++; m_left--;
                if (m_left == 0) begin
                    m_loaded = 1; ex_tx = 1; ex_txd = 8'h4B; m_mode = 0;
                end
            end
            3: begin
                if (halt || w == 32'd4) begin
                    ex_tx = 1; ex_txd = 8'h48; m_mode = 0;
                end
            end
            default: ;
        endcase
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = w; bus.mips_halt = halt;
        @(negedge clk);
        bus.rx_valid = 1'b0; bus.rx_data = $urandom; bus.mips_halt = 1'b0;
        chk("imem_we", bus.imem_we, ex_we);
        if (ex_we) begin
            chk("imem_addr", bus.imem_addr, ex_addr);
            chk("imem_wdata", bus.imem_wdata, w);
        end
        chk("tx_start", bus.tx_start, ex_tx);
        if (ex_tx) chk("tx_data", bus.tx_data, ex_txd);
        chk("error", bus.error, m_err);
        chk("mips_enable", bus.mips_enable, (m_mode == 3) || ex_step);
        chk("mips_reset_pre", bus.mips_reset, pre_rst);
        idle_checks(3);
    endtask

    task automatic pulse_halt();
        bit ex_tx;
        ex_tx = (m_mode == 3);
        if (ex_tx) m_mode = 0;
        @(negedge clk);
        bus.mips_halt = 1'b1;
        @(negedge clk);
        bus.mips_halt = 1'b0;
        chk("halt_tx", bus.tx_start, ex_tx);
        if (ex_tx) chk("halt_txd", bus.tx_data, 8'h48);
        chk("halt_en", bus.mips_enable, 0);
        idle_checks(3);
    endtask

    task automatic load_random(input int n);
        send(32'd1, 0);
        send(32'(n), 0);
        for (int i = 0; i < n; i++) send($urandom, 0);
    endtask

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.mips_halt = 1'b0;
        m_loaded = 0; m_err = 0; m_mode = 0; m_left = 0; m_addr = 0;
        do_reset();

        // fixed three-word load
        send(32'h0000_0001, 0);
        send(32'h0000_0003, 0);
        send(32'hAAAA_0000, 0);
        send(32'hBBBB_0001, 0);
        send(32'hCCCC_0002, 0);

        // run until core halt, with a stray word and stray halt-less traffic
        send(32'd2, 0);
        send(32'h1234_5600, 0);
        pulse_halt();
        pulse_halt();

        // three single steps
        for (int i = 0; i < 3; i++) send(32'd3, 0);
        send(32'd4, 0);

        // error cases
        do_reset();
        send(32'd2, 0);
        send(32'd1, 0);
        send(32'd0, 0);
        send(32'd1, 0);
        send(32'(DEPTH + 1), 0);
        send(32'd3, 0);

        // reset in the middle of a load
        send(32'd1, 0);
        send(32'd4, 0);
        send($urandom, 0);
        send($urandom, 0);
        do_reset();
        send(32'd2, 0);

        // random loads, halted by command, and by command plus core halt together
        for (int k = 0; k < 3; k++) begin
            load_random($urandom_range(1, 8));
            send(32'd2, 0);
            send($urandom | 32'h100, 0);
            send(32'd4, (k == 1));
        end

        // full-depth load
        load_random(DEPTH);
        send(32'd3, 0);

        // random word stream
        for (int k = 0; k < 60; k++) begin
            logic [31:0] w;
            case ($urandom_range(0, 6))
                0: w = 32'd1;
                1: w = 32'd2;
                2: w = 32'd3;
                3: w = 32'd4;
                4: w = 32'($urandom_range(0, 9));
                default: w = $urandom;
            endcase
            send(w, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_loader_ctrl.md
# rx_loader_ctrl

Command sequencer between the UART word assembler and the MIPS core. It consumes each assembled 32-bit receive word and decodes it as a command or payload. It loads a program image into instruction memory at sequential addresses, then gates the processor clock-enable for free-run or single-step execution. It reports completion, halt and error to the transmit side as one-byte status codes.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears every register below
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete word
- rx_data  in  32  assembled receive word
- mips_halt  in  1  level from core: halt instruction retired
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address for imem_we
- imem_wdata  out  32  write data
- mips_enable  out  1  core clock-enable
- mips_reset  out  1  holds core in reset
- tx_start  out  1  one-cycle pulse: send tx_data
- tx_data  out  8  status byte
- error  out  1  sticky protocol error flag

## Operation
- Commands (rx_data in IDLE): CMD_LOAD=32'h0000_0001, CMD_RUN=32'h0000_0002, CMD_STEP=32'h0000_0003, CMD_HALT=32'h0000_0004.
- Status bytes: ST_OK=8'h4B ('K'), ST_HALT=8'h48 ('H'), ST_ERR=8'h45 ('E').
- States: IDLE, LEN, LOAD, RUN, STEP.
- IDLE, CMD_LOAD: clear loaded, clear error, go to LEN.
- IDLE, CMD_RUN with loaded=1: go to RUN. With loaded=0: ST_ERR, set error.
- IDLE, CMD_STEP with loaded=1: go to STEP. With loaded=0: ST_ERR, set error.
- IDLE, CMD_HALT: ignored.
- IDLE, any other word: ST_ERR, set error, stay in IDLE.
- LEN: next word is N. If 1 ≤ N ≤ DEPTH: latch N, addr=0, go to LOAD. Otherwise: ST_ERR, set error, go to IDLE.
- LOAD: each rx_valid writes rx_data at addr, then addr++. After the Nth word: set loaded, send ST_OK, go to IDLE.
- RUN: mips_enable=1. mips_halt or CMD_HALT: mips_enable=0, send ST_HALT, go to IDLE. Other words are ignored.
- STEP: mips_enable=1 for exactly one cycle, then go to IDLE. No status byte is sent.
- mips_reset = ~loaded | (state ∈ {LEN, LOAD}).
- Counter width is ADDR_W+1 so N=DEPTH is representable. addr does not wrap within a load.

## Timing
- All outputs are registered. Reset values: imem_we=0, imem_addr=0, imem_wdata=0, mips_enable=0, mips_reset=1, tx_start=0, tx_data=0, error=0. Reset state is IDLE with loaded=0.
- Every response appears one cycle after the rx_valid that causes it: imem_we, tx_start, and the state change.
- The Nth LOAD write and the ST_OK tx_start assert in the same cycle. mips_reset falls in the following cycle.
- RUN: mips_enable rises one cycle after the CMD_RUN pulse. It falls one cycle after mips_halt is sampled high.
- mips_halt and CMD_HALT in the same cycle: exactly one ST_HALT is sent.
- mips_halt while not in RUN: ignored.
- rx_valid during STEP: dropped. Upstream spacing of at least 4 cycles between words is guaranteed.
- Reset mid-LOAD: loaded=0, so the core stays in reset until a complete reload.
- tx_start is never asserted on two consecutive cycles.

## Structure
- Package rx_loader_pkg holds the CMD_* and ST_* constants and the state enum.
- Single module with one FSM and one word counter. No sub-module is needed.

## Test plan
- Load N=3: words 0x0000_0001, 0x0000_0003, 0xAAAA_0000, 0xBBBB_0001, 0xCCCC_0002 → three imem_we pulses at addr 0,1,2 with matching data; tx_data=0x4B; mips_reset falls one cycle later.
- Load then CMD_RUN → mips_enable=1 until mips_halt is pulsed; mips_enable falls the next cycle; tx_data=0x48.
- Load then 3× CMD_STEP → exactly three single-cycle mips_enable pulses; no tx_start.
- CMD_RUN before any load, and N=0, and N=DEPTH+1 → each gives tx_data=0x45 and error=1; no imem_we; mips_enable stays 0.
- Reset asserted after 2 of 4 LOAD words → all outputs return to reset values; a following CMD_RUN returns 0x45.
- N=DEPTH full load → last write at addr DEPTH-1, then ST_OK; no address wrap.
